decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the CPU core, between `fetch` and execute. Accepts 32-bit instruction words from `fetch` over a valid/ready handshake, assembles two-word (extended-immediate) instructions, and decodes them into a 25-bit `operation` control word, register selects and a 32-bit immediate. The result is held in a single output register with its own valid/ready handshake toward execute. Supports pipeline flush and a HALT stop state.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_in`  in  32  instruction word from `fetch` (`instr_out`).
- `instr_valid`  in  1  `instr_in` is valid.
- `pc_in`  in  32  address of `instr_in`.
- `trg_next_instr`  out  1  ready; a word is consumed on an edge where `instr_valid && trg_next_instr`.
- `flush`  in  1  synchronous discard of all in-flight state.
- `operation`  out  25  decoded control word.
- `imm`  out  32  immediate.
- `pc_out`  out  32  PC of the decoded instruction's first word.
- `illegal`  out  1  decoded word was illegal.
- `op_valid`  out  1  output register holds a decoded op.
- `op_ready`  in  1  execute consumes the op on an edge where `op_valid && op_ready`.

## Operation
- Instruction format:
  - [31:28] class
  - [27:24] func
  - [23:20] dst
  - [19:16] src
  - [15] ext
  - [14:0] imm15
- Classes:
  - 0 NOP
  - 1 ALU
  - 2 ALUI
  - 3 LOAD
  - 4 STORE
  - 5 BRANCH
  - 6 JUMP
  - 7 HALT
  - 8–15 illegal
- `operation` fields:
  - [24:22] class
  - [21:18] func
  - [17] reg_wr
  - [16] mem_rd
  - [15] mem_wr
  - [14] branch
  - [13] uses_imm
  - [12] ext
  - [11:8] dst
  - [7:4] src
  - [3:0] zero
- Flags by class:
  - ALU: reg_wr.
  - ALUI: reg_wr, uses_imm.
  - LOAD: reg_wr, mem_rd, uses_imm.
  - STORE: mem_wr, uses_imm.
  - BRANCH: branch, uses_imm.
  - JUMP: branch, uses_imm, reg_wr.
  - NOP, HALT: no flags set.
- Illegal: class ≥ 8, or ext=1 on NOP/ALU/HALT. Emitted as a normal op with `illegal`=1, `operation`=0, `imm`=0, `pc_out` valid. No state change.
- `imm` width rule:
  - ext=0: `imm` = imm15 sign-extended from bit 14.
  - ext=1: the next accepted word, taken verbatim; its own fields are not decoded.
- States:
  - RUN: accept a first word. If ext=1 and legal, store word and PC, go to EXT, output unchanged. Otherwise load the output register and stay in RUN; HALT goes to HALTED.
  - EXT: next accepted word completes the op, loads the output register, returns to RUN.
  - HALTED: `trg_next_instr`=0; leave only via flush or reset.
- `trg_next_instr` = `reset` deasserted && !`flush` && state≠HALTED && (!`op_valid` || `op_ready`). Combinational from `op_ready`.
- Output register:
  - Loads when a completing word is accepted.
  - Clears `op_valid` when consumed with no simultaneous load.
  - Consume and load on the same edge: the new op replaces the old, `op_valid` stays 1.
- Flush (priority over everything): `op_valid`→0, held first word dropped, state→RUN. A word presented in the flush cycle is not accepted.

## Timing
- Reset (async, while `reset`=0):
  - `op_valid`, `illegal`, `trg_next_instr` = 0.
  - `operation`, `imm`, `pc_out` = 0.
  - State = RUN.
- Single-word latency: word accepted at edge N → `op_valid`=1 after edge N.
- Extended: `op_valid` rises after the edge that accepts the second word. Any number of idle cycles between the two words is allowed.
- Output holds stable while `op_valid && !op_ready`.
- Throughput: one word per cycle with `op_ready` tied high.
- Reset asserted mid-EXT or in HALTED returns to RUN with the held word dropped.

## Test plan
- Reset → hold `reset`=0 with random inputs: all outputs 0. Release: `trg_next_instr`=1 next cycle.
- ALU word 0x13520000 accepted → next cycle `op_valid`=1, `operation`=0x4E0520, `imm`=0, `illegal`=0.
- ALUI word 0x21107FFF → `imm`=0xFFFFFFFF, operation bit 13=1.
- Extended LOAD: 0x30418000, then 3 idle cycles, then 0xDEADBEEF.
  - `op_valid` stays 0 until the second word is accepted.
  - Then `operation`=0xC33410, `imm`=0xDEADBEEF, `pc_out` = first word's PC.
- Backpressure: three ALU words back-to-back, `op_ready`=0 for 5 cycles.
  - Output stable and `trg_next_instr`=0 while stalled.
  - All three ops emerge in order; none lost or duplicated.
- Stop and recovery sequence:
  - 0x90000000 → `illegal`=1.
  - HALT 0x70000000 → after drain, `trg_next_instr` remains 0.
  - Pulse `flush` → back in RUN, accepts again.
  - Flush during EXT → held word dropped, next word decoded as a first word.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
//   Second pipeline stage between fetch and execute. Takes 32-bit instruction
//   words over a valid/ready handshake and joins two-word (extended-immediate)
//   instructions. Each instruction is decoded into a 25-bit control word,
//   register selects and a 32-bit immediate. The result sits in one output
//   register with its own valid/ready handshake. The stage supports flush and
//   a HALT stop state.
// Ports
//   clk, reset (async, active-low)
//   instr_in/instr_valid/pc_in/trg_next_instr : fetch-side handshake
//   flush                                      : synchronous discard
//   operation/imm/pc_out/illegal/op_valid/op_ready : execute-side handshake
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  output logic        trg_next_instr,
  input  logic        flush,
  output logic [24:0] operation,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        illegal,
  output logic        op_valid,
  input  logic        op_ready
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_EXT    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [24:0] operation_q, operation_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        illegal_q, illegal_d;
  logic        op_valid_q, op_valid_d;

  logic        accept;
  logic        consume;
  logic [3:0]  cls;
  logic        ext_bit;
  logic        word_illegal;

  // Builds the control word from a first word; flags depend only on class.
  function automatic logic [24:0] decode_word(input logic [31:0] w);
    logic [24:0] op;
    op        = '0;
    op[24:22] = w[30:28];
    op[21:18] = w[27:24];
    op[12]    = w[15];
    op[11:8]  = w[23:20];
    op[7:4]   = w[19:16];
    case (w[31:28])
      4'd1: op[17] = 1'b1;
      4'd2: begin op[17] = 1'b1; op[13] = 1'b1; end
      4'd3: begin op[17] = 1'b1; op[16] = 1'b1; op[13] = 1'b1; end
      4'd4: begin op[15] = 1'b1; op[13] = 1'b1; end
      4'd5: begin op[14] = 1'b1; op[13] = 1'b1; end
      4'd6: begin op[14] = 1'b1; op[13] = 1'b1; op[17] = 1'b1; end
      default: ;
    endcase
    return op;
  endfunction

  // Ready is combinational from op_ready so a full output register can be
  // replaced on the same edge it drains.
  assign trg_next_instr = reset && !flush && (state_q != ST_HALTED) &&
                          (!op_valid_q || op_ready);

  assign accept  = instr_valid && trg_next_instr;
  assign consume = op_valid_q && op_ready;

  assign cls          = instr_in[31:28];
  assign ext_bit      = instr_in[15];
  assign word_illegal = cls[3] ||
                        (ext_bit && (cls == 4'd0 || cls == 4'd1 || cls == 4'd7));

  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    operation_d = operation_q;
    imm_d       = imm_q;
    pc_out_d    = pc_out_q;
    illegal_d   = illegal_q;
    op_valid_d  = op_valid_q;

    if (consume) begin
      op_valid_d = 1'b0;
    end

    if (flush) begin
      op_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (accept) begin
      if (state_q == ST_EXT) begin
        // Second word is the immediate verbatim; its fields are not decoded.
        operation_d = decode_word(hold_word_q);
        imm_d       = instr_in;
        pc_out_d    = hold_pc_q;
        illegal_d   = 1'b0;
        op_valid_d  = 1'b1;
        state_d     = ST_RUN;
      end else if (!word_illegal && ext_bit) begin
        // Park the first word; output register is left untouched.
        hold_word_d = instr_in;
        hold_pc_d   = pc_in;
        state_d     = ST_EXT;
      end else begin
        operation_d = word_illegal ? 25'd0 : decode_word(instr_in);
        imm_d       = word_illegal ? 32'd0 : {{17{instr_in[14]}}, instr_in[14:0]};
        pc_out_d    = pc_in;
        illegal_d   = word_illegal;
        op_valid_d  = 1'b1;
        if (!word_illegal && cls == 4'd7) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      operation_q <= '0;
      imm_q       <= '0;
      pc_out_q    <= '0;
      illegal_q   <= 1'b0;
      op_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      operation_q <= operation_d;
      imm_q       <= imm_d;
      pc_out_q    <= pc_out_d;
      illegal_q   <= illegal_d;
      op_valid_q  <= op_valid_d;
    end
  end

  assign operation = operation_q;
  assign imm       = imm_q;
  assign pc_out    = pc_out_q;
  assign illegal   = illegal_q;
  assign op_valid  = op_valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Scoreboard bench for decode_stage: stimulus pushes hand-computed expected
//   ops into a queue, a monitor pops and compares on every consumed op.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic        trg_next_instr;
  logic        flush;
  logic [24:0] operation;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;
  logic        op_valid;
  logic        op_ready;

  typedef struct packed {
    logic [24:0] op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .instr_in       (instr_in),
    .instr_valid    (instr_valid),
    .pc_in          (pc_in),
    .trg_next_instr (trg_next_instr),
    .flush          (flush),
    .operation      (operation),
    .imm            (imm),
    .pc_out         (pc_out),
    .illegal        (illegal),
    .op_valid       (op_valid),
    .op_ready       (op_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [24:0] op, input logic [31:0] im,
                          input logic [31:0] pc, input logic il);
    exp_t e;
    e.op = op; e.imm = im; e.pc = pc; e.ill = il;
    exp_q.push_back(e);
  endtask

  // Present a word and hold it until the handshake completes (bounded).
  task automatic send_word(input logic [31:0] w, input logic [31:0] pc);
    bit done;
    done = 0;
    instr_in = w; pc_in = pc; instr_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (trg_next_instr) done = 1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", w);
    end
    $display("sent word 0x%08h pc 0x%08h", w, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every consumed op must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && op_valid && op_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_op: got op 0x%0h imm 0x%0h pc 0x%0h, expected no op",
                 operation, imm, pc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (operation === e.op && imm === e.imm && pc_out === e.pc && illegal === e.ill) begin
          pass_cnt++;
          $display("op ok: op 0x%06h imm 0x%08h pc 0x%08h ill %0b", operation, imm, pc_out, illegal);
        end else begin
          $display("FAIL op_compare: got op 0x%0h imm 0x%0h pc 0x%0h ill %0b, expected op 0x%0h imm 0x%0h pc 0x%0h ill %0b",
                   operation, imm, pc_out, illegal, e.op, e.imm, e.pc, e.ill);
        end
      end
    end
  end

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr_in = $urandom; pc_in = $urandom; instr_valid = 1'($urandom);
      flush = 1'($urandom); op_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_trg", {31'd0, trg_next_instr}, 32'd0);
    check("rst_operation", {7'd0, operation}, 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0; flush = 1'b0; op_ready = 1'b1; instr_in = '0; pc_in = '0;
    reset = 1'b1;
    @(negedge clk);
    check("rel_trg", {31'd0, trg_next_instr}, 32'd1);
    @(posedge clk); #1;

    // Single-word ALU and ALUI
    push_exp(25'h4E0520, 32'h0, 32'h100, 1'b0);
    send_word(32'h13520000, 32'h100);
    push_exp(25'h862100, 32'hFFFFFFFF, 32'h104, 1'b0);
    send_word(32'h21107FFF, 32'h104);
    idle(2);

    // Extended LOAD with idle gap
    send_word(32'h30418000, 32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ext_gap_valid", {31'd0, op_valid}, 32'd0);
      @(posedge clk); #1;
    end
    push_exp(25'hC33410, 32'hDEADBEEF, 32'h200, 1'b0);
    send_word(32'hDEADBEEF, 32'h204);
    idle(2);

    // Backpressure: three ALU words, op_ready low for 5 cycles
    op_ready = 1'b0;
    push_exp(25'h460230, 32'h0, 32'h300, 1'b0);
    push_exp(25'h4A0450, 32'h0, 32'h304, 1'b0);
    push_exp(25'h520670, 32'h0, 32'h308, 1'b0);
    fork
      begin
        send_word(32'h11230000, 32'h300);
        send_word(32'h12450000, 32'h304);
        send_word(32'h14670000, 32'h308);
      end
      begin
        bit seen;
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (op_valid) seen = 1;
        end
        check("stall_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_operation", {7'd0, operation}, 32'h460230);
          check("stall_trg", {31'd0, trg_next_instr}, 32'd0);
        end
        @(posedge clk); #1;
        op_ready = 1'b1;
      end
    join
    idle(3);

    // Illegal words
    push_exp(25'h0, 32'h0, 32'h400, 1'b1);
    send_word(32'h90000000, 32'h400);
    push_exp(25'h0, 32'h0, 32'h402, 1'b1);
    send_word(32'h00008000, 32'h402);

    // HALT then flush recovery
    push_exp(25'h1C00000, 32'h0, 32'h404, 1'b0);
    send_word(32'h70000000, 32'h404);
    instr_in = 32'h13520000; pc_in = 32'h4FF; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted_trg", {31'd0, trg_next_instr}, 32'd0);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_trg", {31'd0, trg_next_instr}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_trg", {31'd0, trg_next_instr}, 32'd1);
    @(posedge clk); #1;
    push_exp(25'h4E0520, 32'h0, 32'h500, 1'b0);
    send_word(32'h13520000, 32'h500);
    idle(2);

    // Flush during EXT drops the held word
    send_word(32'h30418000, 32'h600);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    push_exp(25'h862100, 32'hFFFFFFFF, 32'h604, 1'b0);
    send_word(32'h21107FFF, 32'h604);

    // Drain
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    idle(2);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
